// File: rtl/debounce_pkg.sv
// Shared types for the debounce_sync block: debouncer FSM state encoding.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO  = 2'd0,
        CONFIRM_HI = 2'd1,
        STABLE_HI  = 2'd2,
        CONFIRM_LO = 2'd3
    } deb_state_t;

endpackage

// File: rtl/sync_ff_chain.sv
// Asynchronous-reset multi-flop synchroniser; q is the output of the last flop.
module sync_ff_chain #(
    parameter int unsigned STAGES      = 2,
    parameter logic        RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    if (STAGES < 2) begin : g_bad_stages
        $error("sync_ff_chain: STAGES must be >= 2");
    end

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ff <= {STAGES{RESET_VALUE}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronises and debounces one asynchronous input, giving a clean level
// plus one-cycle rise/fall pulses and a busy flag while a change is being confirmed.
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter logic        RESET_VALUE     = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din_async,
    input  logic en,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
        $error("debounce_sync: DEBOUNCE_CYCLES must be >= 1");
    end

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s;
    deb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             q_r;
    logic             rise_r;
    logic             fall_r;
    logic             busy_r;

    sync_ff_chain #(
        .STAGES      (SYNC_STAGES),
        .RESET_VALUE (RESET_VALUE)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (din_async),
        .q       (s)
    );

    // With a single required sample the CONFIRM states are skipped entirely.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= RESET_VALUE ? STABLE_HI : STABLE_LO;
            cnt    <= '0;
            q_r    <= RESET_VALUE;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            rise_r <= 1'b0;
            fall_r <= 1'b0;
            if (en) begin
                unique case (state)
                    STABLE_LO: begin
                        if (s) begin
                            if (DEBOUNCE_CYCLES == 1) begin
                                state  <= STABLE_HI;
                                q_r    <= 1'b1;
                                rise_r <= 1'b1;
                            end else begin
                                state  <= CONFIRM_HI;
                                cnt    <= CNT_ONE;
                                busy_r <= 1'b1;
                            end
                        end
                    end
                    CONFIRM_HI: begin
                        if (!s) begin
                            state  <= STABLE_LO;
                            cnt    <= '0;
                            busy_r <= 1'b0;
                        end else if (cnt == CNT_LAST) begin
                            state  <= STABLE_HI;
                            cnt    <= '0;
                            q_r    <= 1'b1;
                            rise_r <= 1'b1;
                            busy_r <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    STABLE_HI: begin
                        if (!s) begin
                            if (DEBOUNCE_CYCLES == 1) begin
                                state  <= STABLE_LO;
                                q_r    <= 1'b0;
                                fall_r <= 1'b1;
                            end else begin
                                state  <= CONFIRM_LO;
                                cnt    <= CNT_ONE;
                                busy_r <= 1'b1;
                            end
                        end
                    end
                    CONFIRM_LO: begin
                        if (s) begin
                            state  <= STABLE_HI;
                            cnt    <= '0;
                            busy_r <= 1'b0;
                        end else if (cnt == CNT_LAST) begin
                            state  <= STABLE_LO;
                            cnt    <= '0;
                            q_r    <= 1'b0;
                            fall_r <= 1'b1;
                            busy_r <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign q    = q_r;
    assign rise = rise_r;
    assign fall = fall_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_debounce_sync.sv
// Directed self-checking bench for debounce_sync: default instance plus a DEBOUNCE_CYCLES=1 instance.
module tb_debounce_sync;

    logic clk = 1'b0;
    logic reset_n;
    logic din;
    logic en;
    logic q, rise, fall, busy;
    logic din1;
    logic en1;
    logic q1, rise1, fall1, busy1;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned n_rise1 = 0;
    int unsigned n_fall1 = 0;
    int unsigned n_both = 0;
    int unsigned base_r;
    int unsigned base_f;

    always #5 clk = ~clk;

    debounce_sync #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .RESET_VALUE     (1'b0)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .din_async (din),
        .en        (en),
        .q         (q),
        .rise      (rise),
        .fall      (fall),
        .busy      (busy)
    );

    debounce_sync #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (1),
        .RESET_VALUE     (1'b0)
    ) dut1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .din_async (din1),
        .en        (en1),
        .q         (q1),
        .rise      (rise1),
        .fall      (fall1),
        .busy      (busy1)
    );

    // Pulse monitors sample on the falling edge, away from register updates.
    always @(negedge clk) begin
        if (rise1) n_rise1++;
        if (fall1) n_fall1++;
        if ((rise && fall) || (rise1 && fall1)) n_both++;
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        din     = 1'b1;
        en      = 1'b1;
        din1    = 1'b0;
        en1     = 1'b1;

        // 1: reset state, then rising latency of 5 edges
        tick(3);
        chk("rst_q", q, 1'b0);
        chk("rst_rise", rise, 1'b0);
        chk("rst_fall", fall, 1'b0);
        chk("rst_busy", busy, 1'b0);
        reset_n = 1'b1;
        tick(1);                      // edge 0
        tick(3);                      // edge 3
        chk("t1_busy_e3", busy, 1'b1);
        chk("t1_q_e3", q, 1'b0);
        tick(1);                      // edge 4
        chk("t1_q_e4", q, 1'b0);
        chk("t1_rise_e4", rise, 1'b0);
        tick(1);                      // edge 5
        chk("t1_q_e5", q, 1'b1);
        chk("t1_rise_e5", rise, 1'b1);
        chk("t1_busy_e5", busy, 1'b0);
        tick(1);
        chk("t1_rise_e6", rise, 1'b0);
        chk("t1_q_e6", q, 1'b1);
        chk("t1_q1_idle", q1, 1'b0);

        // 3: falling latency from q=1
        din = 1'b0;
        tick(4);                      // edge 3
        chk("t3_busy_e3", busy, 1'b1);
        tick(1);                      // edge 4
        chk("t3_q_e4", q, 1'b1);
        tick(1);                      // edge 5
        chk("t3_q_e5", q, 1'b0);
        chk("t3_fall_e5", fall, 1'b1);
        chk("t3_rise_e5", rise, 1'b0);
        tick(1);
        chk("t3_fall_e6", fall, 1'b0);

        // 2: three-sample pulse is one short of acceptance
        din = 1'b1;
        tick(3);                      // edges 0..2
        din = 1'b0;
        tick(2);                      // edge 4
        chk("t2_busy_e4", busy, 1'b1);
        chk("t2_q_e4", q, 1'b0);
        tick(1);                      // edge 5
        chk("t2_busy_e5", busy, 1'b0);
        chk("t2_q_e5", q, 1'b0);
        chk("t2_rise_e5", rise, 1'b0);
        tick(2);
        chk("t2_q_late", q, 1'b0);

        // 4: reset mid-confirm aborts the candidate
        din = 1'b1;
        tick(4);                      // edge 3
        chk("t4_busy_pre", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("t4_q_rst", q, 1'b0);
        chk("t4_busy_rst", busy, 1'b0);
        #1;
        reset_n = 1'b1;
        tick(5);                      // edge 4 after release
        chk("t4_q_r4", q, 1'b0);
        tick(1);                      // edge 5 after release
        chk("t4_q_r5", q, 1'b1);
        chk("t4_rise_r5", rise, 1'b1);

        // 5: en=0 holds count mid-confirm
        din = 1'b0;
        tick(8);
        chk("t5_q_lo", q, 1'b0);
        din = 1'b1;
        tick(4);                      // edge 3 -> cnt=2
        en = 1'b0;
        tick(6);
        chk("t5_q_hold", q, 1'b0);
        chk("t5_busy_hold", busy, 1'b1);
        chk("t5_rise_hold", rise, 1'b0);
        en = 1'b1;
        tick(1);
        chk("t5_q_en1", q, 1'b0);
        tick(1);
        chk("t5_q_en2", q, 1'b1);
        chk("t5_rise_en2", rise, 1'b1);

        // 5b: en=0 in STABLE_LO ignores din
        din = 1'b0;
        tick(8);
        chk("t5b_q_lo", q, 1'b0);
        en  = 1'b0;
        din = 1'b1;
        tick(8);
        chk("t5b_q_ign", q, 1'b0);
        chk("t5b_busy_ign", busy, 1'b0);
        en = 1'b1;
        tick(3);
        chk("t5b_q_e3", q, 1'b0);
        chk("t5b_busy_e3", busy, 1'b1);
        tick(1);
        chk("t5b_q_e4", q, 1'b1);

        // 6: DEBOUNCE_CYCLES=1 follows din two edges later
        din1 = 1'b1;
        tick(2);                      // edge 1
        chk("t6_q1_e1", q1, 1'b0);
        tick(1);                      // edge 2
        chk("t6_q1_e2", q1, 1'b1);
        chk("t6_rise1_e2", rise1, 1'b1);
        chk("t6_busy1", busy1, 1'b0);
        tick(1);
        chk("t6_rise1_e3", rise1, 1'b0);
        din1 = 1'b0;
        tick(3);
        chk("t6_q1_lo", q1, 1'b0);
        chk("t6_fall1", fall1, 1'b1);
        tick(2);

        // 6b: one-period glitch passes through as a rise/fall pair
        din1 = 1'b1;
        tick(1);                      // edge 0
        din1 = 1'b0;
        tick(2);                      // edge 2
        chk("t6b_q1_e2", q1, 1'b1);
        chk("t6b_rise1_e2", rise1, 1'b1);
        tick(1);                      // edge 3
        chk("t6b_q1_e3", q1, 1'b0);
        chk("t6b_fall1_e3", fall1, 1'b1);
        tick(2);

        // 6c: half-period glitch straddling one edge gives exactly one pair
        base_r = n_rise1;
        base_f = n_fall1;
        #6 din1 = 1'b1;
        #5 din1 = 1'b0;
        tick(8);
        chk("t6c_rises", n_rise1 - base_r, 32'd1);
        chk("t6c_falls", n_fall1 - base_f, 32'd1);
        chk("t6c_q1_end", q1, 1'b0);

        chk("no_rise_fall_overlap", n_both, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
